// File: rtl/simon_uart_pkg.sv
// Shared definitions for the SIMON UART transmit path.
//   BLOCK_W / BLOCK_BYTES : size of one cipher block and its byte count.
//   tx_state_e            : state set of the 8N1 byte serializer.
//   calc_clks_per_bit     : clock cycles per serial bit (truncated division).
package simon_uart_pkg;

  localparam int BLOCK_W     = 64;
  localparam int BLOCK_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 serializer with its own baud counter.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   start : load din and begin a frame; honoured in IDLE and in the last
//           cycle of STOP, so frames can follow each other with no gap
//   din   : byte to send, LSB first
//   tx    : registered serial output, idle high
//   done  : registered pulse during the last cycle of the stop bit
module uart_tx_byte
  import simon_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (baud_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          // tx drops at the accepting edge so the start bit occupies the
          // very next cycle.
          state_d   = START;
          shift_d   = din;
          bit_cnt_d = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        // Pre-decode one cycle early so the registered pulse lands on the
        // final stop cycle.
        if (baud_q == PRE_LAST) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          bit_cnt_d = '0;
          if (start) begin
            state_d = START;
            shift_d = din;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign done = done_q;

endmodule

// File: rtl/uart_block_tx.sv
// Sends one 64-bit SIMON block as 8 back-to-back UART 8N1 frames.
//   clk_100MHz : system clock (rising edge)
//   reset_n    : asynchronous active-low reset; aborts any frame in flight
//   blk_valid  : upstream offers blk_data
//   blk_data   : block, sampled only on the accepting edge
//   blk_ready  : high while no block is in flight
//   tx         : registered serial line, idle high
//   busy       : block transmission in progress
//   byte_done  : pulse in the last cycle of each stop bit
//   blk_done   : pulse in the first idle cycle after the 8th stop bit;
//                a new block may be accepted in that same cycle
module uart_block_tx
  import simon_uart_pkg::*;
#(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 9600,
  parameter int CLKS_PER_BIT   = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               blk_valid,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               blk_ready,
  output logic               tx,
  output logic               busy,
  output logic               byte_done,
  output logic               blk_done
);

  localparam logic [2:0] LAST_BYTE = 3'(BLOCK_BYTES - 1);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic               active_q, active_d;
  logic               blk_done_q, blk_done_d;

  logic               byte_start;
  logic [7:0]         byte_din;
  logic               byte_tx;
  logic               byte_done_w;
  logic [2:0]         next_idx;

  function automatic logic [7:0] pick_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [2:0] idx);
    logic [2:0] lane;
    lane = (MSB_BYTE_FIRST != 0) ? (3'd7 - idx) : idx;
    return blk[{lane, 3'b000} +: 8];
  endfunction

  assign next_idx = byte_idx_q + 3'd1;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      block_q    <= '0;
      byte_idx_q <= '0;
      active_q   <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      block_q    <= block_d;
      byte_idx_q <= byte_idx_d;
      active_q   <= active_d;
      blk_done_q <= blk_done_d;
    end
  end

  always_comb begin
    block_d    = block_q;
    byte_idx_d = byte_idx_q;
    active_d   = active_q;
    blk_done_d = 1'b0;
    byte_start = 1'b0;
    byte_din   = pick_byte(block_q, next_idx);

    if (!active_q && blk_valid) begin
      // On accept the block register is not loaded yet, so the first byte
      // is taken straight from the input bus.
      block_d    = blk_data;
      byte_idx_d = '0;
      active_d   = 1'b1;
      byte_start = 1'b1;
      byte_din   = pick_byte(blk_data, 3'd0);
    end else if (active_q && byte_done_w) begin
      if (byte_idx_q == LAST_BYTE) begin
        active_d   = 1'b0;
        blk_done_d = 1'b1;
      end else begin
        // Chain the next frame directly out of the current stop bit.
        byte_idx_d = next_idx;
        byte_start = 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk_100MHz),
    .rst_n(reset_n),
    .start(byte_start),
    .din  (byte_din),
    .tx   (byte_tx),
    .done (byte_done_w)
  );

  assign blk_ready = !active_q;
  assign busy      = active_q;
  assign tx        = byte_tx;
  assign byte_done = byte_done_w;
  assign blk_done  = blk_done_q;

endmodule

// File: tb/tb_uart_block_tx.sv
// Self-checking bench for uart_block_tx: two fast instances (MSB-first and
// LSB-first byte order, 4 clocks per bit) and one default-parameter instance.
module tb_uart_block_tx;

  localparam int CPB     = 4;
  localparam int DEF_CPB = 100000000 / 9600;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  valid;
  logic [63:0] blk_data_s [3];
  logic        ready_s [3];
  logic        tx_s    [3];
  logic        busy_s  [3];
  logic        bd_s    [3];
  logic        kd_s    [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_block_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1)) dut0 (
    .clk_100MHz(clk), .reset_n(reset_n), .blk_valid(valid[0]),
    .blk_data(blk_data_s[0]), .blk_ready(ready_s[0]), .tx(tx_s[0]),
    .busy(busy_s[0]), .byte_done(bd_s[0]), .blk_done(kd_s[0]));

  uart_block_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(0)) dut1 (
    .clk_100MHz(clk), .reset_n(reset_n), .blk_valid(valid[1]),
    .blk_data(blk_data_s[1]), .blk_ready(ready_s[1]), .tx(tx_s[1]),
    .busy(busy_s[1]), .byte_done(bd_s[1]), .blk_done(kd_s[1]));

  uart_block_tx dut2 (
    .clk_100MHz(clk), .reset_n(reset_n), .blk_valid(valid[2]),
    .blk_data(blk_data_s[2]), .blk_ready(ready_s[2]), .tx(tx_s[2]),
    .busy(busy_s[2]), .byte_done(bd_s[2]), .blk_done(kd_s[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {tx, busy, blk_ready, byte_done, blk_done}
  function automatic logic [4:0] obs(input int d);
    return {tx_s[d], busy_s[d], ready_s[d], bd_s[d], kd_s[d]};
  endfunction

  // Byte i on the line: counted from bits 63:56 when MSB-first, else 7:0.
  function automatic logic [7:0] exp_byte(input logic [63:0] blk, input int i, input bit msb);
    int sh;
    sh = msb ? (7 - i) * 8 : i * 8;
    return 8'(blk >> sh);
  endfunction

  // Entered at a negedge with blk valid already presented on instance d.
  // Checks every cycle of the block against the ideal waveform and decodes
  // each frame at mid-bit. chain: present nxt in the blk_done cycle.
  // abort_k: return right after checking cycle abort_k (0 = never).
  task automatic run_block(input int d, input logic [63:0] blk, input bit msb,
                           input bit churn, input bit chain, input logic [63:0] nxt,
                           input int abort_k);
    int         last;
    int         idx;
    int         f;
    int         p;
    logic       etx;
    logic [7:0] eb;
    logic [7:0] got_b;
    logic [4:0] exp_v;
    last  = 80 * CPB + 1;
    got_b = '0;
    check($sformatf("d%0d accept_ready", d), 64'(ready_s[d]), 64'd1);
    @(posedge clk);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k <= 80 * CPB) begin
        idx = (k - 1) / CPB;
        f   = idx / 10;
        p   = idx % 10;
        eb  = exp_byte(blk, f, msb);
        if (p == 0)      etx = 1'b0;
        else if (p == 9) etx = 1'b1;
        else             etx = eb[p-1];
        exp_v = {etx, 1'b1, 1'b0, ((k % (10 * CPB)) == 0), 1'b0};
        if ((k - 1) % CPB == CPB / 2) begin
          if (p >= 1 && p <= 8) got_b[p-1] = tx_s[d];
          if (p == 9) check($sformatf("d%0d byte%0d", d, f), 64'(got_b), 64'(eb));
        end
      end else begin
        exp_v = 5'b10101;
      end
      check($sformatf("d%0d cyc%0d", d, k), 64'(obs(d)), 64'(exp_v));
      if (k == abort_k) return;
      if (churn && k < last) blk_data_s[d] = {$urandom, $urandom};
      if (k == last) begin
        if (chain) begin
          valid[d]      = 1'b1;
          blk_data_s[d] = nxt;
        end else begin
          valid[d] = 1'b0;
        end
      end
    end
    $display("blk dut=%0d data=%h msb_first=%0d churn=%0d chain=%0d", d, blk, msb, churn, chain);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    int          cnt;
    int          pulses;
    int          d;

    reset_n = 1'b0;
    valid   = '0;
    for (int i = 0; i < 3; i++) blk_data_s[i] = '0;

    // Reset held with valid asserted: idle line, ready, no pulses.
    valid[0]      = 1'b1;
    blk_data_s[0] = 64'h0123456789ABCDEF;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold d0", 64'(obs(0)), 64'(5'b10100));
    end
    check("rst_hold d1", 64'(obs(1)), 64'(5'b10100));
    reset_n = 1'b1;
    // First accept on the very next edge after release.
    run_block(0, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 64'h0, 0);
    @(negedge clk);
    check("idle d0", 64'(obs(0)), 64'(5'b10100));

    // LSB-first ordering.
    @(negedge clk);
    valid[1]      = 1'b1;
    blk_data_s[1] = 64'h0123456789ABCDEF;
    run_block(1, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, 64'h0, 0);

    // Back-to-back blocks with data churn while busy, then edge data.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    @(negedge clk);
    valid[0]      = 1'b1;
    blk_data_s[0] = a;
    run_block(0, a, 1'b1, 1'b1, 1'b1, b, 0);
    run_block(0, b, 1'b1, 1'b1, 1'b1, 64'h0, 0);
    run_block(0, 64'h0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_block(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h0, 0);

    // Random blocks on either fast instance.
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      @(negedge clk);
      valid[d]      = 1'b1;
      blk_data_s[d] = a;
      run_block(d, a, (d == 0), 1'($urandom_range(0, 1)), 1'b0, 64'h0, 0);
    end

    // Reset during byte 3, data bit 4 (all-zero block so tx is low there).
    @(negedge clk);
    valid[0]      = 1'b1;
    blk_data_s[0] = 64'h0;
    run_block(0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, (3 * 10 + 5) * CPB + 2);
    valid[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_rst d0", 64'(obs(0)), 64'(5'b10100));
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    cnt     = 0;
    for (int k = 0; k < 100 * CPB; k++) begin
      @(negedge clk);
      if (bd_s[0] || kd_s[0]) pulses++;
      if (obs(0) != 5'b10100) cnt++;
    end
    check("abort_pulses d0", 64'(pulses), 64'd0);
    check("abort_idle d0", 64'(cnt), 64'd0);

    // Default parameters: start bit and first data bit (0x01 -> bit0 = 1)
    // each last CLK_FREQ/BAUD cycles.
    @(negedge clk);
    valid[2]      = 1'b1;
    blk_data_s[2] = 64'h0123456789ABCDEF;
    check("d2 accept_ready", 64'(ready_s[2]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid[2] = 1'b0;
    check("d2 busy", 64'(busy_s[2]), 64'd1);
    cnt = 0;
    while (tx_s[2] == 1'b0 && cnt < 2 * DEF_CPB) begin
      cnt++;
      @(negedge clk);
    end
    check("d2 start_len", 64'(cnt), 64'(DEF_CPB));
    cnt = 0;
    while (tx_s[2] == 1'b1 && cnt < 2 * DEF_CPB) begin
      cnt++;
      @(negedge clk);
    end
    check("d2 bit0_len", 64'(cnt), 64'(DEF_CPB));
    $display("blk dut=2 data=%h start/bit0 timing checked", 64'h0123456789ABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_block_tx.md
Name: uart_block_tx

Overview:
- Transmit-side counterpart of the byte-to-block receive path.
- Accepts one 64-bit SIMON output block over a valid/ready handshake.
- Sends the block as 8 consecutive UART 8N1 frames on the serial tx line.
- Sits between the simon64_96 output and the board USB-RS232 Tx pin; no FIFO is needed on the transmit side.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (truncated, 10416), clock cycles per serial bit; must be >= 2.
- MSB_BYTE_FIRST, 1, 1 = send bits 63:56 first; 0 = send bits 7:0 first.

Ports:
- clk_100MHz  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  upstream has a block on blk_data.
- blk_data  in  64  block to transmit; sampled only on accept.
- blk_ready  out  1  block can be accepted this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  transmission in progress.
- byte_done  out  1  one-cycle pulse at the end of each stop bit.
- blk_done  out  1  one-cycle pulse when the 8th stop bit completes.

Behaviour:
- Reset (asynchronous, active low):
  - tx=1, busy=0, byte_done=0, blk_done=0, blk_ready=1.
  - FSM goes to IDLE; counters and shift register clear.
  - Takes effect immediately, including mid-frame: the frame in progress is dropped and no done pulse is issued.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - blk_ready=1, tx=1, busy=0.
  - Accept on the rising edge where blk_valid && blk_ready.
  - On accept: latch blk_data into the block register, byte_idx=0, bit_cnt=0, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, beginning the cycle after accept.
  - Then go to DATA and load the current byte.
- Current byte selection:
  - MSB_BYTE_FIRST=1: byte = block[63-8*byte_idx -: 8].
  - MSB_BYTE_FIRST=0: byte = block[8*byte_idx +: 8].
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - bit_cnt 0..7; after bit 7 go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle, byte_done pulses for one cycle.
  - If byte_idx<7: byte_idx+1, go to START with no idle gap.
  - If byte_idx=7: go to IDLE; blk_done is asserted in the first IDLE cycle.
- Busy / ready:
  - busy=1 in START, DATA and STOP.
  - blk_ready = (state==IDLE).
- Timing:
  - One frame = 10*CLKS_PER_BIT cycles; one block = 80*CLKS_PER_BIT cycles.
  - blk_done is asserted exactly 80*CLKS_PER_BIT+1 cycles after the accept edge.
  - A new block may be accepted in the blk_done cycle. The minimum block period is therefore 80*CLKS_PER_BIT+1.
- Simultaneous / illegal inputs:
  - blk_valid while busy: ignored, nothing latched.
  - blk_data changes after accept: no effect on the line.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1, then wraps.
  - bit_cnt is 3 bits; byte_idx is 3 bits.
  - No overflow beyond these ranges is permitted.
- Output registering:
  - tx is registered; no combinational path from any input to tx.
  - byte_done and blk_done are registered pulses.

Decomposition:
- Package simon_uart_pkg holds:
  - BLOCK_W=64 and BLOCK_BYTES=8.
  - The tx state enum {IDLE, START, DATA, STOP}.
  - A function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- Sub-module uart_tx_byte:
  - Single-byte 8N1 serializer with its own baud counter.
  - Ports: start, din[7:0], tx, done.
- uart_block_tx wraps uart_tx_byte and owns the block register, byte sequencing and the handshake.

Test Plan (CLKS_PER_BIT=4 unless stated):
1. Reset: hold reset_n=0 with blk_valid=1 -> tx=1, busy=0, blk_ready=1, no pulses. After release, the first accept occurs on the next edge.
2. Single block 64'h0123456789ABCDEF, MSB_BYTE_FIRST=1:
   - Decoded line bytes are 01,23,45,67,89,AB,CD,EF.
   - The first frame is tx = 0,1,0,0,0,0,0,0,0,1, each bit 4 cycles.
   - byte_done pulses 8 times at 40-cycle spacing.
   - blk_done is asserted at accept+321.
3. Same block with MSB_BYTE_FIRST=0 -> bytes EF,CD,AB,89,67,45,23,01.
4. Back-to-back blocks:
   - Hold blk_valid=1 and change blk_data every cycle while busy -> only the initially accepted value is sent.
   - The second block is accepted in the blk_done cycle, and its start bit begins on the next cycle.
5. Reset mid-operation: assert reset_n=0 during byte 3, bit 4 -> tx=1 in the same cycle (asynchronous). After release: blk_ready=1, and no byte_done or blk_done occurs for the aborted block.
6. Edge data:
   - 64'h0: all data bits 0; stop bits still 1.
   - 64'hFFFFFFFFFFFFFFFF: only the start bits are low, 4 cycles each.
   - Rerun scenario 2 with default parameters: each bit is 10416 cycles.
